// File: rtl/npu_cq_pkg.sv
// Shared definitions for the multi-queue command fetcher: descriptor layout,
// opcodes and the fetch FSM state encoding.
package npu_cq_pkg;

  localparam logic [7:0] OPC_NOP      = 8'h00;
  localparam logic [7:0] OPC_DMA_COPY = 8'h01;
  localparam logic [7:0] OPC_EVENT    = 8'h02;

  localparam int DESC_BYTES = 32;
  localparam int OFF_OPC    = 0;
  localparam int OFF_SRC    = 8;
  localparam int OFF_DST    = 16;
  localparam int OFF_LEN    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_FETCH,
    ST_WAIT_RSP,
    ST_DECODE,
    ST_DMA_REQ,
    ST_DMA_WAIT,
    ST_ADVANCE
  } cq_state_e;

  // Producer tails are byte offsets; only whole descriptors count as work.
  function automatic logic [31:0] align_desc(input logic [31:0] off);
    return {off[31:5], 5'b00000};
  endfunction

endpackage

// File: rtl/cq_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer itself is held by the parent.
module cq_rr_arbiter
  import npu_cq_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int c;
    logic hit;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      c        = (int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i;
      hit      = !any && req[c];
      grant[c] = grant[c] | hit;
      idx      = hit ? IW'(c) : idx;
      any      = any | hit;
    end
  end

endmodule

// File: rtl/cq_multi_fetcher.sv
// Multi-ring command-queue front end: round-robin descriptor fetch, DMA_COPY
// dispatch, per-queue head advance and empty/event/error status.
module cq_multi_fetcher
  import npu_cq_pkg::*;
#(
  parameter int NUM_QUEUES  = 4,
  parameter int ADDR_W      = 64,
  parameter int DESC_W      = 256,
  parameter int DMA_TIMEOUT = 1024,
  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_QUEUES-1:0]        q_enable,
  input  logic [NUM_QUEUES*ADDR_W-1:0] q_base,
  input  logic [NUM_QUEUES*32-1:0]     q_size,
  input  logic [NUM_QUEUES*32-1:0]     q_tail,
  output logic [NUM_QUEUES*32-1:0]     q_head,
  input  logic [NUM_QUEUES-1:0]        q_err_clr,
  output logic [NUM_QUEUES-1:0]        q_empty,
  output logic [NUM_QUEUES-1:0]        q_event,
  output logic [NUM_QUEUES-1:0]        q_err,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_rsp_valid,
  input  logic [DESC_W-1:0]            mem_rsp_data,
  output logic                         dma_req_valid,
  input  logic                         dma_req_ready,
  output logic [ADDR_W-1:0]            dma_req_src,
  output logic [ADDR_W-1:0]            dma_req_dst,
  output logic [31:0]                  dma_req_bytes,
  output logic [QW-1:0]                dma_req_qid,
  input  logic                         dma_resp_done,
  output logic                         busy
);

  cq_state_e             state_r, state_nxt_s;
  logic [QW-1:0]         rr_ptr_r, qid_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DESC_W-1:0]     desc_r;
  logic [31:0]           head_r [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] err_r;
  logic [31:0]           tmo_cnt_r;

  logic [NUM_QUEUES-1:0] eligible_s, grant_s, err_set_s;
  logic [QW-1:0]         idx_s;
  logic                  any_s;
  logic [7:0]            opc_s;
  logic [31:0]           len_s, head_next_s;
  logic [32:0]           head_sum_s;
  logic                  tmo_s, bad_opc_s, tmo_hit_s;
  logic                  unused_bits_s;

  assign opc_s         = desc_r[OFF_OPC*8 +: 8];
  assign len_s         = desc_r[OFF_LEN*8 +: 32];
  assign tmo_s         = (DMA_TIMEOUT != 0) && (tmo_cnt_r == 32'(DMA_TIMEOUT - 1));
  assign unused_bits_s = ^{desc_r, q_tail, grant_s};

  // Per-queue work detection and status levels.
  always_comb begin
    eligible_s = '0;
    q_empty    = '0;
    q_head     = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      q_empty[q]         = (head_r[q] == align_desc(q_tail[q*32 +: 32]));
      eligible_s[q]      = q_enable[q] && !err_r[q] && !q_empty[q];
      q_head[q*32 +: 32] = head_r[q];
    end
  end

  cq_rr_arbiter #(.N(NUM_QUEUES), .IW(QW)) u_arb (
    .req   (eligible_s),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  // Ring wrap: a head landing at or past the ring size returns to zero.
  always_comb begin
    head_sum_s  = {1'b0, head_r[qid_r]} + 33'd32;
    head_next_s = (head_sum_s >= {1'b0, q_size[qid_r*32 +: 32]}) ? 32'd0 : head_sum_s[31:0];
    bad_opc_s   = (state_r == ST_DECODE) && (opc_s != OPC_NOP) &&
                  (opc_s != OPC_DMA_COPY) && (opc_s != OPC_EVENT);
    tmo_hit_s   = (state_r == ST_DMA_WAIT) && !dma_resp_done && tmo_s;
    err_set_s   = '0;
    err_set_s[qid_r] = bad_opc_s | tmo_hit_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:     state_nxt_s = any_s ? ST_ARB : ST_IDLE;
      ST_ARB:      state_nxt_s = any_s ? ST_FETCH : ST_IDLE;
      ST_FETCH:    state_nxt_s = mem_req_ready ? ST_WAIT_RSP : ST_FETCH;
      ST_WAIT_RSP: state_nxt_s = mem_rsp_valid ? ST_DECODE : ST_WAIT_RSP;
      ST_DECODE: begin
        case (opc_s)
          OPC_NOP:      state_nxt_s = ST_ADVANCE;
          OPC_DMA_COPY: state_nxt_s = (len_s == 32'd0) ? ST_ADVANCE : ST_DMA_REQ;
          OPC_EVENT:    state_nxt_s = ST_ADVANCE;
          default:      state_nxt_s = ST_IDLE;
        endcase
      end
      ST_DMA_REQ:  state_nxt_s = dma_req_ready ? ST_DMA_WAIT : ST_DMA_REQ;
      ST_DMA_WAIT: state_nxt_s = dma_resp_done ? ST_ADVANCE : (tmo_s ? ST_IDLE : ST_DMA_WAIT);
      ST_ADVANCE:  state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state and latched descriptor.
  always_comb begin
    mem_req_valid = (state_r == ST_FETCH);
    mem_req_addr  = addr_r;
    dma_req_valid = (state_r == ST_DMA_REQ);
    dma_req_src   = desc_r[OFF_SRC*8 +: ADDR_W];
    dma_req_dst   = desc_r[OFF_DST*8 +: ADDR_W];
    dma_req_bytes = len_s;
    dma_req_qid   = qid_r;
    busy          = (state_r != ST_IDLE);
    q_err         = err_r;
    q_event       = '0;
    q_event[qid_r] = (state_r == ST_ADVANCE) && (opc_s == OPC_EVENT);
  end

  // Datapath: arbitration latch, descriptor capture, heads, errors, timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= '0;
      qid_r     <= '0;
      addr_r    <= '0;
      desc_r    <= '0;
      err_r     <= '0;
      tmo_cnt_r <= 32'd0;
      for (int q = 0; q < NUM_QUEUES; q++) head_r[q] <= 32'd0;
    end else begin
      if (state_r == ST_ARB && any_s) begin
        qid_r    <= idx_s;
        rr_ptr_r <= (idx_s == QW'(NUM_QUEUES - 1)) ? '0 : idx_s + QW'(1);
        addr_r   <= q_base[idx_s*ADDR_W +: ADDR_W] + ADDR_W'(head_r[idx_s]);
      end
      if (state_r == ST_WAIT_RSP && mem_rsp_valid) desc_r <= mem_rsp_data;
      if (state_r == ST_ADVANCE) head_r[qid_r] <= head_next_s;
      err_r     <= (err_r & ~q_err_clr) | err_set_s;
      tmo_cnt_r <= (state_r == ST_DMA_WAIT) ? tmo_cnt_r + 32'd1 : 32'd0;
    end
  end

endmodule

// File: tb/tb_cq_multi_fetcher.sv
// Scoreboard bench for cq_multi_fetcher: directed ring scenarios push expected
// fetch addresses, DMA commands and event pulses; a monitor pops and compares.
module tb_cq_multi_fetcher;

  localparam int NQ = 4;
  localparam int AW = 64;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [NQ-1:0]   q_enable;
  logic [NQ*AW-1:0] q_base;
  logic [NQ*32-1:0] q_size, q_tail, q_head;
  logic [NQ-1:0]   q_err_clr, q_empty, q_event, q_err;
  logic            mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_rsp_data;
  logic            dma_req_valid, dma_req_ready, dma_resp_done, busy;
  logic [AW-1:0]   dma_req_src, dma_req_dst;
  logic [31:0]     dma_req_bytes;
  logic [1:0]      dma_req_qid;

  cq_multi_fetcher #(.NUM_QUEUES(NQ), .ADDR_W(AW), .DESC_W(DW), .DMA_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .q_enable(q_enable), .q_base(q_base), .q_size(q_size),
    .q_tail(q_tail), .q_head(q_head), .q_err_clr(q_err_clr), .q_empty(q_empty),
    .q_event(q_event), .q_err(q_err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst),
    .dma_req_bytes(dma_req_bytes), .dma_req_qid(dma_req_qid),
    .dma_resp_done(dma_resp_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] bytes;
    logic [1:0]  qid;
  } dma_t;

  logic [63:0]  exp_mem_q[$];
  dma_t         exp_dma_q[$];
  logic [NQ-1:0] exp_evt_q[$];
  logic [255:0] mem [logic [63:0]];
  bit           auto_done;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [255:0] mk_desc(input logic [7:0] opc, input logic [63:0] src,
                                           input logic [63:0] dst, input logic [31:0] n);
    logic [255:0] d;
    d = '0;
    d[7:0]     = opc;
    d[127:64]  = src;
    d[191:128] = dst;
    d[223:192] = n;
    return d;
  endfunction

  function automatic logic [31:0] head_of(input int q);
    return q_head[q*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s unexpected output actual=0x%0h required=none", name, act);
  endtask

  // Monitor: every presented transaction is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) begin
      if (exp_mem_q.size() == 0) unexpected("mem_addr", mem_req_addr);
      else check("mem_addr", mem_req_addr, exp_mem_q.pop_front());
    end
    if (dma_req_valid && dma_req_ready) begin
      if (exp_dma_q.size() == 0) unexpected("dma_req", dma_req_src);
      else begin
        dma_t e;
        e = exp_dma_q.pop_front();
        check("dma_src", dma_req_src, e.src);
        check("dma_dst", dma_req_dst, e.dst);
        check("dma_bytes", {32'd0, dma_req_bytes}, {32'd0, e.bytes});
        check("dma_qid", {62'd0, dma_req_qid}, {62'd0, e.qid});
      end
    end
    if (q_event != '0) begin
      if (exp_evt_q.size() == 0) unexpected("q_event", {60'd0, q_event});
      else check("q_event", {60'd0, q_event}, {60'd0, exp_evt_q.pop_front()});
    end
  end

  // Memory model: one-cycle read latency from the accepted request.
  initial begin
    logic [63:0] a;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        a = mem_req_addr;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem.exists(a) ? mem[a] : '0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // DMA model: completes a few cycles after acceptance when enabled.
  initial begin
    dma_resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dma_req_valid && dma_req_ready && auto_done) begin
        repeat (3) @(posedge clk);
        #1 dma_resp_done = 1'b1;
        @(posedge clk); #1;
        dma_resp_done = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic wait_quiet(input string name);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      idle = busy ? 0 : idle + 1;
    end
    if (idle < 3) unexpected({name, "_timeout"}, {63'd0, busy});
  endtask

  task automatic wait_dma_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dma_req_valid && n < 500);
    if (!dma_req_valid) unexpected({name, "_dma_timeout"}, 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    q_enable  = '0;
    q_tail    = '0;
    q_err_clr = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; q_enable = '0; q_tail = '0; q_err_clr = '0;
    mem_req_ready = 1'b1; dma_req_ready = 1'b1; auto_done = 1'b1;
    for (int q = 0; q < NQ; q++) begin
      q_base[q*AW +: AW] = 64'(q) * 64'h10_0000;
      q_size[q*32 +: 32] = 32'h1000;
    end
    reset_dut();
    @(negedge clk);
    check("rst_heads", q_head[63:0], 64'd0);
    check("rst_heads_hi", q_head[127:64], 64'd0);
    check("rst_err", {60'd0, q_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_dma_valid", {63'd0, dma_req_valid}, 64'd0);
    check("rst_event", {60'd0, q_event}, 64'd0);
    check("rst_empty", {60'd0, q_empty}, 64'hF);

    // Four queues, two NOPs each, tails raised together: strict round robin.
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NQ; q++) exp_mem_q.push_back(64'(q) * 64'h10_0000 + 64'(r * 32));
    q_enable = 4'hF;
    q_tail   = {32'd64, 32'd64, 32'd64, 32'd64};
    wait_quiet("rr");
    for (int q = 0; q < NQ; q++) check("rr_head", {32'd0, head_of(q)}, 64'd64);
    check("rr_empty", {60'd0, q_empty}, 64'hF);

    // Two DMA_COPY descriptors on queue 0.
    reset_dut();
    mem[64'h0]  = mk_desc(8'h01, 64'h0, 64'h1_0000, 32'd256);
    mem[64'h20] = mk_desc(8'h01, 64'h0, 64'h1_0000, 32'd256);
    exp_mem_q.push_back(64'h0);
    exp_mem_q.push_back(64'h20);
    exp_dma_q.push_back('{src: 64'h0, dst: 64'h1_0000, bytes: 32'd256, qid: 2'd0});
    exp_dma_q.push_back('{src: 64'h0, dst: 64'h1_0000, bytes: 32'd256, qid: 2'd0});
    q_enable = 4'b0001;
    q_tail[31:0] = 32'd64;
    wait_quiet("dma2");
    check("dma2_head0", {32'd0, head_of(0)}, 64'd64);
    check("dma2_empty0", {63'd0, q_empty[0]}, 64'd1);
    check("dma2_err", {60'd0, q_err}, 64'd0);

    // Ring wrap on queue 2 with a 96-byte ring; tail low bits are ignored.
    q_size[95:64] = 32'd96;
    q_enable = 4'b0101;
    exp_mem_q.push_back(64'h20_0000);
    exp_mem_q.push_back(64'h20_0020);
    q_tail[95:64] = 32'd64 + 32'd7;
    wait_quiet("wrap1");
    check("wrap_head_64", {32'd0, head_of(2)}, 64'd64);
    exp_mem_q.push_back(64'h20_0040);
    q_tail[95:64] = 32'd0;
    wait_quiet("wrap2");
    check("wrap_head_0", {32'd0, head_of(2)}, 64'd0);
    check("wrap_empty2", {63'd0, q_empty[2]}, 64'd1);

    // EVENT then illegal opcode on queue 1; clearing the error refetches it.
    mem[64'h10_0000] = mk_desc(8'h02, 64'h0, 64'h0, 32'd0);
    mem[64'h10_0020] = mk_desc(8'h7F, 64'h0, 64'h0, 32'd0);
    exp_mem_q.push_back(64'h10_0000);
    exp_mem_q.push_back(64'h10_0020);
    exp_evt_q.push_back(4'b0010);
    q_enable = 4'b0111;
    q_tail[63:32] = 32'd64;
    wait_quiet("evt");
    check("evt_err1", {63'd0, q_err[1]}, 64'd1);
    check("evt_head1", {32'd0, head_of(1)}, 64'd32);
    check("evt_empty1", {63'd0, q_empty[1]}, 64'd0);
    exp_mem_q.push_back(64'h10_0020);
    q_err_clr = 4'b0010;
    @(negedge clk);
    q_err_clr = '0;
    wait_quiet("reerr");
    check("reerr_err1", {63'd0, q_err[1]}, 64'd1);
    check("reerr_head1", {32'd0, head_of(1)}, 64'd32);

    // DMA timeout on queue 3 while queue 0 still has work.
    auto_done = 1'b0;
    mem[64'h30_0000] = mk_desc(8'h01, 64'hAAAA_0000, 64'hBBBB_0000, 32'h40);
    exp_mem_q.push_back(64'h30_0000);
    exp_mem_q.push_back(64'h40);
    exp_dma_q.push_back('{src: 64'hAAAA_0000, dst: 64'hBBBB_0000, bytes: 32'h40, qid: 2'd3});
    q_enable = 4'hF;
    q_tail[127:96] = 32'd32;
    q_tail[31:0]   = 32'd96;
    wait_dma_valid("tmo");
    repeat (16) @(negedge clk);
    check("tmo_err3_before", {63'd0, q_err[3]}, 64'd0);
    @(negedge clk);
    check("tmo_err3_after", {63'd0, q_err[3]}, 64'd1);
    wait_quiet("tmo");
    check("tmo_head3", {32'd0, head_of(3)}, 64'd0);
    check("tmo_head0", {32'd0, head_of(0)}, 64'd96);
    check("tmo_err0", {63'd0, q_err[0]}, 64'd0);

    // Reset while waiting on DMA; a late completion must be ignored.
    mem[64'h60] = mk_desc(8'h01, 64'h1, 64'h2, 32'd8);
    exp_mem_q.push_back(64'h60);
    exp_dma_q.push_back('{src: 64'h1, dst: 64'h2, bytes: 32'd8, qid: 2'd0});
    q_enable = 4'b0001;
    q_tail[31:0] = 32'd128;
    wait_dma_valid("rstw");
    repeat (3) @(negedge clk);
    rst = 1'b1; q_enable = '0; q_tail = '0;
    @(negedge clk);
    rst = 1'b0;
    dma_resp_done = 1'b1;
    @(negedge clk);
    dma_resp_done = 1'b0;
    repeat (5) @(negedge clk);
    check("rstw_heads", q_head[63:0], 64'd0);
    check("rstw_heads_hi", q_head[127:64], 64'd0);
    check("rstw_busy", {63'd0, busy}, 64'd0);
    check("rstw_dma_valid", {63'd0, dma_req_valid}, 64'd0);
    check("rstw_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rstw_err", {60'd0, q_err}, 64'd0);

    check("drain_mem", 64'(exp_mem_q.size()), 64'd0);
    check("drain_dma", 64'(exp_dma_q.size()), 64'd0);
    check("drain_evt", 64'(exp_evt_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
